// File: rtl/top_module_hls_deadlock_pkg.sv
// Shared types and helpers for the HLS deadlock report controller.
package top_module_hls_deadlock_pkg;

  localparam int unsigned MAX_PROC_NUM = 32;

  typedef enum logic [2:0] {
    IDLE,
    ORIGIN,
    TRACE,
    REPORT,
    DONE
  } dl_state_e;

  function automatic int unsigned proc_id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Lowest set bit index; 0 when the vector is empty.
  function automatic int lowest_set_idx(input logic [MAX_PROC_NUM-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_PROC_NUM - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/top_module_hls_deadlock_prio_enc.sv
// Combinational lowest-index priority encoder over the detect vector.
module top_module_hls_deadlock_prio_enc
  import top_module_hls_deadlock_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    vec_i,
  output logic            any_o,
  output logic [ID_W-1:0] idx_o
);

  assign any_o = |vec_i;
  assign idx_o = ID_W'(lowest_set_idx(MAX_PROC_NUM'(vec_i)));

endmodule

// File: rtl/top_module_hls_deadlock_report_ctrl.sv
// Deadlock report controller: picks an origin, tracks the token round trip, emits a one-shot report.
// Optional TRACE watchdog enabled by defining DL_TOKEN_TIMEOUT_EN.
module top_module_hls_deadlock_report_ctrl
  import top_module_hls_deadlock_pkg::*;
#(
  parameter int unsigned PROC_NUM       = 4,
  parameter int unsigned PROC_ID_W      = proc_id_w(PROC_NUM),
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PROC_NUM-1:0]  dl_detect_vec,
  input  logic [PROC_NUM-1:0]  token_ret_vec,
  output logic                 dl_detect_in,
  output logic [PROC_NUM-1:0]  origin_vec,
  output logic [PROC_NUM-1:0]  token_clear_vec,
  output logic                 rpt_vld,
  input  logic                 rpt_rdy,
  output logic [PROC_ID_W-1:0] rpt_origin_id,
  output logic [PROC_NUM-1:0]  rpt_cycle_mask,
  output logic                 rpt_timeout,
  output logic                 dl_found
);

  // Elaboration-time parameter sanity.
  if (PROC_NUM < 2 || PROC_ID_W < proc_id_w(PROC_NUM) ||
      TIMEOUT_CYCLES < 2 || CNT_W < $clog2(TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("top_module_hls_deadlock_report_ctrl: inconsistent parameters");
  end

  dl_state_e             state_q, state_d;
  logic [PROC_ID_W-1:0]  origin_id_q, origin_id_d;
  logic [PROC_NUM-1:0]   mask_q, mask_d;
  logic [PROC_NUM-1:0]   origin_vec_q, origin_vec_d;
  logic                  dl_in_q, dl_in_d;
  logic                  found_q, found_d;
  logic                  rpt_vld_q, rpt_vld_d;
  logic                  rpt_to_q, rpt_to_d;

  logic                  det_any;
  logic [PROC_ID_W-1:0]  det_idx;
  logic                  tok_return;
  logic                  timeout_hit;

  top_module_hls_deadlock_prio_enc #(
    .N    (PROC_NUM),
    .ID_W (PROC_ID_W)
  ) u_prio_enc (
    .vec_i (dl_detect_vec),
    .any_o (det_any),
    .idx_o (det_idx)
  );

  // The origin unit flags its own token return together with its dl_detect_out.
  assign tok_return = (state_q == TRACE) &&
                      token_ret_vec[origin_id_q] && dl_detect_vec[origin_id_q];

`ifdef DL_TOKEN_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == TRACE) && !tok_return &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ORIGIN)     cnt_d = '0;
    else if (state_q == TRACE) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (det_any) state_d = ORIGIN;
      ORIGIN:  state_d = TRACE;
      TRACE:   if (tok_return || timeout_hit) state_d = REPORT;
      REPORT:  if (rpt_rdy) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values and the combinational token clear.
  always_comb begin
    origin_id_d     = origin_id_q;
    mask_d          = mask_q;
    origin_vec_d    = '0;
    dl_in_d         = dl_in_q;
    found_d         = found_q;
    rpt_vld_d       = rpt_vld_q;
    rpt_to_d        = rpt_to_q;
    token_clear_vec = '0;
    unique case (state_q)
      IDLE: begin
        if (det_any) begin
          origin_id_d  = det_idx;
          origin_vec_d = PROC_NUM'(1) << det_idx;
          dl_in_d      = 1'b1;
          found_d      = 1'b1;
        end
      end
      ORIGIN: mask_d = origin_vec_q | token_ret_vec;
      TRACE: begin
        mask_d = mask_q | token_ret_vec;
        if (tok_return) begin
          if (reset) token_clear_vec[origin_id_q] = 1'b1;
          rpt_vld_d = 1'b1;
        end else if (timeout_hit) begin
          if (reset) token_clear_vec = '1;
          rpt_vld_d = 1'b1;
          rpt_to_d  = 1'b1;
        end
      end
      REPORT:  if (rpt_rdy) rpt_vld_d = 1'b0;
      DONE:    ;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      origin_id_q  <= '0;
      mask_q       <= '0;
      origin_vec_q <= '0;
      dl_in_q      <= 1'b0;
      found_q      <= 1'b0;
      rpt_vld_q    <= 1'b0;
      rpt_to_q     <= 1'b0;
    end else begin
      origin_id_q  <= origin_id_d;
      mask_q       <= mask_d;
      origin_vec_q <= origin_vec_d;
      dl_in_q      <= dl_in_d;
      found_q      <= found_d;
      rpt_vld_q    <= rpt_vld_d;
      rpt_to_q     <= rpt_to_d;
    end
  end

  assign dl_detect_in   = dl_in_q;
  assign origin_vec     = origin_vec_q;
  assign rpt_vld        = rpt_vld_q;
  assign rpt_origin_id  = origin_id_q;
  assign rpt_cycle_mask = mask_q;
  assign rpt_timeout    = rpt_to_q;
  assign dl_found       = found_q;

endmodule
